// File: rtl/rgb2yuv_pipe.sv
// rgb2yuv_pipe: three-stage RGB -> Y'UV converter with valid/ready on both sides.
//   S1: per-channel products for the mode captured with the pixel
//   S2: the three signed sums
//   S3: rounded/shifted, chroma offset to mid-scale, clamped result + sat flag
// Build option: define RGB2YUV_ROUND_EN for round-half-up. Without it the
// shift floors toward -inf. Latency is the same in both builds.
module rgb2yuv_pipe #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [3*PIX_W-1:0] s_data,
    input  logic               s_sof,
    input  logic               s_eol,
    input  logic               mode,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [3*PIX_W-1:0] m_data,
    output logic               m_sof,
    output logic               m_eol,
    input  logic               sat_clr,
    output logic [CNT_W-1:0]   sat_cnt
);
    // Products and sums fit in PIX_W+10 signed bits, so nothing can overflow.
    localparam int SW = PIX_W + 10;
    typedef logic signed [SW-1:0] sval_t;

`ifdef RGB2YUV_ROUND_EN
    localparam sval_t RND = sval_t'(128);
`else
    localparam sval_t RND = sval_t'(0);
`endif
    localparam sval_t HALF = sval_t'(2 ** (PIX_W - 1));
    localparam sval_t PMAX = sval_t'(2 ** PIX_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Row-major {Y,U,V} x {R,G,B} coefficients, Q0.8.
    localparam int C601 [9] = '{77, 150, 29, -38, -74, 112, 157, -132, -25};
    localparam int C709 [9] = '{54, 183, 19, -26, -86, 112, 157, -143, -14};

    function automatic sval_t coef(input logic bt709, input int idx);
        return sval_t'(bt709 ? C709[idx] : C601[idx]);
    endfunction

    // Returns {sat, pix}: pix clamped into [0, 2^PIX_W-1].
    function automatic logic [PIX_W:0] clamp_pix(input sval_t x);
        if (x < 0) begin
            return {1'b1, {PIX_W{1'b0}}};
        end else if (x > PMAX) begin
            return {1'b1, {PIX_W{1'b1}}};
        end else begin
            return {1'b0, x[PIX_W-1:0]};
        end
    endfunction

    // Stage registers and their next-state values
    logic                 v1_q, v2_q, v3_q;
    logic                 v1_d, v2_d, v3_d;
    logic [1:0]           sb1_q, sb2_q, sb3_q;
    sval_t                p_q   [9];
    sval_t                p_d   [9];
    sval_t                sum_q [3];
    sval_t                sum_d [3];
    logic [3*PIX_W-1:0]   data3_q, data3_d;
    logic                 sat3_q, sat3_d;
    logic [CNT_W-1:0]     sat_cnt_q, sat_cnt_d;
    sval_t                comp_x [3];
    logic [PIX_W:0]       y_c, u_c, v_c;

    // Ready chain: a stage may load when it is empty or its occupant moves on.
    logic rdy1, rdy2, rdy3;
    logic ld1, ld2, ld3;

    assign rdy3    = !v3_q || m_ready;
    assign rdy2    = !v2_q || rdy3;
    assign rdy1    = !v1_q || rdy2;
    assign s_ready = rdy1;

    assign ld1 = s_valid && rdy1;
    assign ld2 = v1_q && rdy2;
    assign ld3 = v2_q && rdy3;

    // Valid next-state: a ready stage takes whatever the previous stage offers.
    always_comb begin
        v1_d = rdy1 ? s_valid : v1_q;
        v2_d = rdy2 ? v1_q    : v2_q;
        v3_d = rdy3 ? v2_q    : v3_q;
    end

    // S1 datapath: zero-extend components and multiply by the captured mode's coefficients.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            comp_x[c] = sval_t'({10'b0, s_data[(2-c)*PIX_W +: PIX_W]});
        end
        for (int k = 0; k < 9; k++) begin
            p_d[k] = comp_x[k % 3] * coef(mode, k);
        end
    end

    // S2 datapath: one signed sum per output component.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            sum_d[c] = p_q[3*c] + p_q[3*c+1] + p_q[3*c+2];
        end
    end

    // S3 datapath: scale back to pixel range, offset chroma, clamp and flag.
    always_comb begin
        y_c     = clamp_pix((sum_q[0] + RND) >>> 8);
        u_c     = clamp_pix(((sum_q[1] + RND) >>> 8) + HALF);
        v_c     = clamp_pix(((sum_q[2] + RND) >>> 8) + HALF);
        data3_d = {y_c[PIX_W-1:0], u_c[PIX_W-1:0], v_c[PIX_W-1:0]};
        sat3_d  = y_c[PIX_W] | u_c[PIX_W] | v_c[PIX_W];
    end

    // Saturation counter: clear wins, otherwise count clamped transfers and stick at max.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (v3_q && m_ready && sat3_q && (sat_cnt_q != CNT_MAX)) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    // S1 register: products and sideband of the accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            sb1_q <= '0;
            p_q   <= '{default: '0};
        end else begin
            v1_q <= v1_d;
            if (ld1) begin
                sb1_q <= {s_sof, s_eol};
                p_q   <= p_d;
            end
        end
    end

    // S2 register: sums travel with their sideband.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q  <= 1'b0;
            sb2_q <= '0;
            sum_q <= '{default: '0};
        end else begin
            v2_q <= v2_d;
            if (ld2) begin
                sb2_q <= sb1_q;
                sum_q <= sum_d;
            end
        end
    end

    // S3 register: only loads on a real transfer, so outputs hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q    <= 1'b0;
            sb3_q   <= '0;
            data3_q <= '0;
            sat3_q  <= 1'b0;
        end else begin
            v3_q <= v3_d;
            if (ld3) begin
                sb3_q   <= sb2_q;
                data3_q <= data3_d;
                sat3_q  <= sat3_d;
            end
        end
    end

    // Saturation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign m_valid = v3_q;
    assign m_data  = data3_q;
    assign m_sof   = sb3_q[1];
    assign m_eol   = sb3_q[0];
    assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_rgb2yuv_pipe.sv
// Directed bench for rgb2yuv_pipe: vector table, mode toggle, backpressure
// stream, counter edges (second instance with CNT_W=4) and mid-stream reset.
module tb_rgb2yuv_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic        s_eol = 1'b0;
    logic        mode = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [23:0] m_data;
    logic        m_sof;
    logic        m_eol;
    logic        sat_clr = 1'b0;
    logic [15:0] sat_cnt;

    logic        s_ready4, m_valid4, m_sof4, m_eol4;
    logic [23:0] m_data4;
    logic [3:0]  sat_cnt4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rgb2yuv_pipe #(.PIX_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol), .mode(mode),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .sat_clr(sat_clr), .sat_cnt(sat_cnt)
    );

    rgb2yuv_pipe #(.PIX_W(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready4),
        .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol), .mode(mode),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
        .m_sof(m_sof4), .m_eol(m_eol4), .sat_clr(sat_clr), .sat_cnt(sat_cnt4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fl256(input int x);
        int q;
        q = x / 256;
        if (x < 0 && q * 256 != x) q = q - 1;
        return q;
    endfunction

    // Reference: {sat, Y, U, V}
    function automatic logic [24:0] model(input logic [7:0] r8, input logic [7:0] g8,
                                          input logic [7:0] b8, input logic md);
        int cf [9];
        int r, g, b, rnd;
        int o [3];
        logic sat;
        r = int'(r8); g = int'(g8); b = int'(b8);
        if (md) cf = '{54, 183, 19, -26, -86, 112, 157, -143, -14};
        else    cf = '{77, 150, 29, -38, -74, 112, 157, -132, -25};
`ifdef RGB2YUV_ROUND_EN
        rnd = 128;
`else
        rnd = 0;
`endif
        for (int c = 0; c < 3; c++) begin
            o[c] = fl256(cf[3*c]*r + cf[3*c+1]*g + cf[3*c+2]*b + rnd);
            if (c > 0) o[c] = o[c] + 128;
        end
        sat = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (o[c] < 0)   begin o[c] = 0;   sat = 1'b1; end
            if (o[c] > 255) begin o[c] = 255; sat = 1'b1; end
        end
        return {sat, 8'(o[0]), 8'(o[1]), 8'(o[2])};
    endfunction

    typedef struct {
        logic [7:0] r, g, b;
        logic       md;
        logic [7:0] y, u, v;
        logic       sat;
    } vec_t;

    vec_t tv [6];

    typedef struct {
        logic [23:0] data;
        logic        sof, eol, sat;
    } exp_t;

    initial begin
        int   lat;
        int   exp_sat;
        int   sent, got, occ, seen;
        exp_t q[$];
        exp_t e;
        logic [24:0] mres;
        logic [23:0] pix  [10];
        logic        pmd  [10];
        logic        prev_stall;
        logic [25:0] prev_out;

        // r g b mode -> y u v sat, hand-computed for each build
        tv[0] = '{8'd255, 8'd255, 8'd255, 1'b0, 8'd255, 8'd128, 8'd128, 1'b0};
`ifdef RGB2YUV_ROUND_EN
        tv[1] = '{8'd255, 8'd0,   8'd0,   1'b0, 8'd77,  8'd90,  8'd255, 1'b1};
        tv[2] = '{8'd0,   8'd0,   8'd255, 1'b0, 8'd29,  8'd240, 8'd103, 1'b0};
        tv[3] = '{8'd0,   8'd255, 8'd0,   1'b1, 8'd182, 8'd42,  8'd0,   1'b1};
`else
        tv[1] = '{8'd255, 8'd0,   8'd0,   1'b0, 8'd76,  8'd90,  8'd255, 1'b1};
        tv[2] = '{8'd0,   8'd0,   8'd255, 1'b0, 8'd28,  8'd239, 8'd103, 1'b0};
        tv[3] = '{8'd0,   8'd255, 8'd0,   1'b1, 8'd182, 8'd42,  8'd0,   1'b1};
`endif
        tv[4] = '{8'd0,   8'd0,   8'd0,   1'b1, 8'd0,   8'd128, 8'd128, 1'b0};
        tv[5] = '{8'd255, 8'd255, 8'd255, 1'b1, 8'd255, 8'd128, 8'd128, 1'b0};

        // Reset state
        #12;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_sideband", {m_sof, m_eol}, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_s_ready", s_ready, 1);

        // Table: single pixels, latency, data, sideband, sat count
        exp_sat = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = {tv[i].r, tv[i].g, tv[i].b};
            mode    = tv[i].md;
            s_sof   = (i == 0);
            s_eol   = (i == 5);
            @(posedge clk);
            #1;
            s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
            lat = 0;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (m_valid) begin lat = k; break; end
            end
            check("vec_latency", lat, 3);
            check("vec_data", m_data, {tv[i].y, tv[i].u, tv[i].v});
            check("vec_sideband", {m_sof, m_eol}, {i == 0, i == 5});
            if (tv[i].sat) exp_sat++;
            @(negedge clk);
            check("vec_sat_cnt", sat_cnt, exp_sat);
        end

        // Back-to-back pixels with mode toggled: blue BT.601 then green BT.709
        @(negedge clk);
        s_valid = 1'b1; s_data = {tv[2].r, tv[2].g, tv[2].b}; mode = 1'b0;
        @(posedge clk);
        #1;
        s_data = {tv[3].r, tv[3].g, tv[3].b}; mode = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (m_valid) begin lat = k; break; end
        end
        check("tog_latency", lat, 2);
        check("tog_blue", m_data, {tv[2].y, tv[2].u, tv[2].v});
        @(negedge clk);
        check("tog_green_valid", m_valid, 1);
        check("tog_green", m_data, {tv[3].y, tv[3].u, tv[3].v});
        exp_sat++;
        @(negedge clk);
        check("tog_sat_cnt", sat_cnt, exp_sat);

        // Backpressure stream of 10 pixels against the model
        for (int i = 0; i < 10; i++) begin
            pix[i] = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
            pmd[i] = 1'($urandom_range(0, 1));
        end
        pix[3] = 24'hFF0000;
        sent = 0; got = 0; occ = 0;
        prev_stall = 1'b0; prev_out = '0;
        for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
            @(negedge clk);
            m_ready = 1'($urandom_range(0, 1));
            if (sent < 10) begin
                s_valid = 1'b1; s_data = pix[sent]; mode = pmd[sent];
                s_sof = (sent == 0); s_eol = (sent == 9);
            end else begin
                s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
            end
            #1;
            check("bp_s_ready", s_ready, !(occ == 3 && !m_ready));
            if (prev_stall) begin
                check("bp_hold_valid", m_valid, 1);
                check("bp_hold_out", {m_data, m_sof, m_eol}, prev_out);
            end
            if (m_valid && m_ready) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("bp_out", {m_data, m_sof, m_eol}, {e.data, e.sof, e.eol});
                    if (e.sat) exp_sat++;
                end else begin
                    check("bp_unexpected_out", m_valid, 0);
                end
                got++; occ--;
            end
            if (s_valid && s_ready) begin
                mres   = model(pix[sent][23:16], pix[sent][15:8], pix[sent][7:0], pmd[sent]);
                e.data = mres[23:0]; e.sat = mres[24];
                e.sof  = (sent == 0); e.eol = (sent == 9);
                q.push_back(e);
                sent++; occ++;
            end
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_data, m_sof, m_eol};
        end
        check("bp_all_out", got, 10);
        @(negedge clk);
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; m_ready = 1'b1;
        check("bp_sat_cnt", sat_cnt, exp_sat);

        // Counter edges: clear, then 16 saturating pixels into the CNT_W=4 instance
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        check("clr_sat_cnt", sat_cnt, 0);
        check("clr_sat_cnt4", sat_cnt4, 0);
        s_valid = 1'b1; s_data = 24'hFF0000; mode = 1'b0;
        for (int i = 0; i < 16; i++) @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("cnt4_m_valid", m_valid4, 1);
        check("cnt4_m_data", {m_data4, m_sof4, m_eol4}, {tv[1].y, tv[1].u, tv[1].v, 2'b00});
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("cnt16_value", sat_cnt, 16);
        check("cnt4_hold_max", sat_cnt4, 15);

        // sat_clr coinciding with a saturated transfer
        s_valid = 1'b1; s_data = 24'hFF0000; mode = 1'b0;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (m_valid) begin lat = k; break; end
        end
        check("clrsat_latency", lat, 3);
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        @(negedge clk);
        check("clrsat_sat_cnt", sat_cnt, 0);
        check("clrsat_sat_cnt4", sat_cnt4, 0);
        check("clrsat_drained", m_valid, 0);

        // Put a saturated count on the counter, then fill the pipe and reset mid-stream
        s_valid = 1'b1; s_data = 24'hFF0000;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("pre_rst_sat_cnt", sat_cnt, 1);
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 24'hFFFFFF; mode = 1'b0;
        for (int i = 0; i < 3; i++) @(posedge clk);
        @(negedge clk);
        check("full_s_ready", s_ready, 0);
        check("full_m_valid", m_valid, 1);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_data", m_data, 0);
        check("midrst_sat_cnt", sat_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_valid) seen++;
        end
        check("flush_no_stale", seen, 0);
        check("flush_s_ready", s_ready, 1);
        check("flush_s_ready4", s_ready4, 1);
        check("flush_sat_cnt", sat_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb2yuv_pipe.md
Name: rgb2yuv_pipe

Overview:
- Pipelined, parametrised RGB to Y'UV converter with valid/ready streaming on both sides and a runtime-selectable coefficient set (BT.601 or BT.709).
- Sits between the camera pixel source and the downstream filter stages.
- Carries frame/line sideband in lock-step with the pixels.
- Offsets chroma to mid-scale, clamps every component to the pixel range, and counts saturated pixels.

Parameters:
- PIX_W, 8, bits per colour component on input and output.
- CNT_W, 16, width of the saturation counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_data  in  3*PIX_W  {R,G,B}, R in the MSBs
- s_sof  in  1  start-of-frame flag, qualified by s_valid
- s_eol  in  1  end-of-line flag, qualified by s_valid
- mode  in  1  0 = BT.601, 1 = BT.709; sampled with each accepted pixel
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_data  out  3*PIX_W  {Y,U,V}, Y in the MSBs
- m_sof  out  1  s_sof delayed with its pixel
- m_eol  out  1  s_eol delayed with its pixel
- sat_clr  in  1  synchronous clear of sat_cnt
- sat_cnt  out  CNT_W  number of output pixels with any component clamped

Behaviour:
- Reset: one clock domain; rst_n asynchronous, active-low. While rst_n=0: all stage valids, m_valid, m_data, m_sof, m_eol and sat_cnt are 0; s_ready=1 once out of reset. Reset asserted mid-stream discards all in-flight pixels.
- Pipeline structure: three stages.
  - S1 registers the per-channel products for the selected mode.
  - S2 registers the three signed sums.
  - S3 registers the rounded, shifted, offset and clamped result, plus the sat flag. S3 drives m_*.
- Latency and throughput: 3 cycles from input handshake to m_valid with m_ready held high; throughput 1 pixel/cycle.
- Flow control:
  - Each stage loads when it is empty or when its contents move on in the same cycle.
  - s_ready = !S1_valid || S1 advances. The ready chain is combinational from m_ready.
  - With m_ready=0 the pipeline holds up to 3 pixels; then s_ready=0.
  - Bubbles collapse.
  - m_data, m_sof and m_eol are stable while m_valid && !m_ready.
- Coefficients are Q0.8 signed integers; mode is captured per pixel and never mixes within a pixel.
  - BT.601: Y = 77R+150G+29B; U = -38R-74G+112B; V = 157R-132G-25B.
  - BT.709: Y = 54R+183G+19B; U = -26R-86G+112B; V = 157R-143G-14B.
- Arithmetic:
  - Components are zero-extended to signed PIX_W+10 bits; sums use that width (no overflow).
  - result = (sum + RND) >>> 8, arithmetic shift (floor).
  - U and V then add 2^(PIX_W-1).
  - Clamp each component to [0, 2^PIX_W-1].
  - sat flag = any of the three components clamped.
- sat_cnt:
  - Increments on m_valid && m_ready when that pixel's sat flag is set.
  - Holds at 2^CNT_W-1; no wrap.
  - sat_clr has priority: sat_clr plus a simultaneous saturated transfer gives 0.
- Sideband: s_sof and s_eol pass through unmodified, with no checking or repair.

Optional Feature:
- Macro RGB2YUV_ROUND_EN.
- Defined: RND = 128 (round half up).
- Undefined: RND = 0 (truncate toward -inf). No other difference; latency unchanged.

Test Plan:
- Reset and flush: assert rst_n=0 with 3 pixels in flight and m_ready=0; release -> m_valid=0, sat_cnt=0, s_ready=1, and no stale pixel ever appears on the output.
- White and red, BT.601, ROUND_EN defined, PIX_W=8, m_ready=1:
  - (255,255,255) -> {255,128,128} after exactly 3 cycles, no sat.
  - (255,0,0) -> {77,90,255}, sat_cnt increments to 1 (V clamped from 284).
- Blue BT.601 then green BT.709, mode toggled between back-to-back pixels:
  - (0,0,255) -> {29,240,103}.
  - (0,255,0) -> {182,42,0}, sat_cnt +1 (V clamped from -14).
  - Confirms per-pixel mode capture.
- Truncation: build without RGB2YUV_ROUND_EN; (255,0,0) BT.601 -> Y=76 (rounded build gives 77).
- Backpressure: stream 10 pixels with s_sof on the first and s_eol on the last, m_ready toggling pseudo-randomly:
  - Output order, data and sideband match the model.
  - s_ready=0 only when 3 pixels are held.
  - m_data is stable while stalled.
- Counter edges:
  - Force sat_cnt to 2^CNT_W-1 using CNT_W=4 and 16 saturating pixels -> sat_cnt holds at 15.
  - Assert sat_clr in the same cycle as a saturated transfer -> sat_cnt=0.
